clk_div_bank: RTL and testbench

Parametrised, fully synchronous clock-generation bank and the successor to the fixed four-output PLL test block. It produces NUM_CH divided clock outputs from the system clock. Each channel has its own runtime-programmable divide ratio, high time (duty cycle) and phase offset, loaded through a valid/ready config port. A `locked` flag is asserted once all channels have run phase-aligned for a settle period. It sits next to the PLL and supplies slow, phase-related strobes and clocks to downstream logic without a vendor PLL.

---
 rtl/clk_div_bank.sv | 141 ++++++++++++++
 tb/tb_clk_div_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers sharing one restart edge,
// so every channel's phase offset is exact relative to the others.
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  parameter int DEF_HIGH    = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTART = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int CH_W1 = CH_W + 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
  localparam logic [CH_W:0]    NUM_CH_V    = CH_W1'(NUM_CH);
  localparam logic [DIV_W-1:0] DEF_DIV_V   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH_V  = DIV_W'(DEF_HIGH);
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO         = DIV_W'(2);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [SET_W-1:0] settle_cnt;
  logic             accept;
  logic             legal;
  logic             wr_legal;
  logic             run_next;
  logic             load_phase;

  logic [DIV_W-1:0] div_r    [NUM_CH];
  logic [DIV_W-1:0] high_r   [NUM_CH];
  logic [DIV_W-1:0] phase_r  [NUM_CH];
  logic [DIV_W-1:0] cnt      [NUM_CH];
  logic [DIV_W-1:0] cnt_next [NUM_CH];
  logic [NUM_CH-1:0] clk_next;
  logic [NUM_CH-1:0] tick_next;

  assign cfg_ready = (state != S_RESTART);
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = ({1'b0, cfg_ch} < NUM_CH_V) && (cfg_div >= TWO);
  assign wr_legal  = accept & legal;
  assign locked    = (state == S_LOCKED);

  // en low overrides everything; a legal write while running forces a re-align.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_next = S_RESTART;
        S_RESTART: state_next = S_SETTLE;
        S_SETTLE: begin
          if (wr_legal)
            state_next = S_RESTART;
          else if (settle_cnt == SETTLE_LAST)
            state_next = S_LOCKED;
        end
        S_LOCKED: begin
          if (wr_legal)
            state_next = S_RESTART;
        end
        default:   state_next = S_IDLE;
      endcase
    end
  end

  assign run_next   = (state_next == S_SETTLE) || (state_next == S_LOCKED);
  assign load_phase = (state == S_RESTART) && (state_next == S_SETTLE);

  // Outputs are derived from the next counter value so they carry no lag vs cnt.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i]  = '0;
      clk_next[i]  = 1'b0;
      tick_next[i] = 1'b0;
      if (load_phase)
        cnt_next[i] = (phase_r[i] < div_r[i]) ? phase_r[i] : '0;
      else if (run_next)
        cnt_next[i] = (cnt[i] >= div_r[i] - ONE) ? '0 : cnt[i] + ONE;
      if (run_next) begin
        clk_next[i]  = (cnt_next[i] < high_r[i]);
        tick_next[i] = (cnt_next[i] == '0) && (high_r[i] != '0) &&
                       (high_r[i] < div_r[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      cfg_err    <= 1'b0;
      clk_out    <= '0;
      tick       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_r[i]   <= DEF_DIV_V;
        high_r[i]  <= DEF_HIGH_V;
        phase_r[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      state      <= state_next;
      settle_cnt <= ((state == S_SETTLE) && (state_next == S_SETTLE)) ?
                    settle_cnt + SET_ONE : '0;
      cfg_err    <= accept & ~legal;
      clk_out    <= clk_next;
      tick       <= tick_next;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_next[i];
        if (wr_legal && (cfg_ch == CH_W'(i))) begin
          div_r[i]   <= cfg_div;
          high_r[i]  <= cfg_high;
          phase_r[i] <= cfg_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, reprogramming, phase offsets,
// boundary high/phase/div values, rejected writes, en drop and mid-run reset.
module tb_clk_div_bank;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_high;
  logic [DIV_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  int tests_run    = 0;
  int tests_failed = 0;

  // ch0 4/2/0, ch1 4/7/0, ch2 4/2/1, ch3 4/0/0
  logic [3:0] exp_clk_a  [8] = '{4'b0111, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0011, 4'b0010, 4'b0110};
  logic [3:0] exp_tick_a [8] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0100};
  // ch0 4/2/0, ch1 4/7/0, ch2 4/2/9, ch3 255/1/0
  logic [3:0] exp_clk_b  [5] = '{4'b1111, 4'b0111, 4'b0010, 4'b0010, 4'b0111};
  logic [3:0] exp_tick_b [5] = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0101};

  clk_div_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
    .DEF_DIV(2), .DEF_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic stepClock;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One write presented for exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] ch, input logic [DIV_W-1:0] dv,
                               input logic [DIV_W-1:0] hi, input logic [DIV_W-1:0] ph);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_high  = hi;
    cfg_phase = ph;
    stepClock();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;
    repeat (2) stepClock();
    checkOutput("rst_clk_out", clk_out, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);

    // Defaults: div=2 high=1 on all channels
    rst_n = 1'b1;
    en    = 1'b1;
    stepClock();
    checkOutput("e0_cfg_ready", cfg_ready, 0);
    checkOutput("e0_clk_out", clk_out, 0);
    for (int k = 1; k <= 17; k++) begin
      stepClock();
      checkOutput($sformatf("def_clk_k%0d", k), clk_out, (k % 2 == 1) ? 4'hF : 4'h0);
      checkOutput($sformatf("def_tick_k%0d", k), tick, (k % 2 == 1) ? 4'hF : 4'h0);
      if (k >= 16)
        checkOutput($sformatf("def_locked_k%0d", k), locked, (k == 17) ? 1 : 0);
    end

    // Reprogram ch1 to div=5 high=2 while locked
    applyStimulus(2'd1, 8'd5, 8'd2, 8'd0);
    checkOutput("w1_locked", locked, 0);
    checkOutput("w1_cfg_ready", cfg_ready, 0);
    checkOutput("w1_clk_out", clk_out, 0);
    for (int m = 1; m <= 17; m++) begin
      stepClock();
      checkOutput($sformatf("ch1_clk_m%0d", m), clk_out[1], ((m - 1) % 5 < 2) ? 1 : 0);
      checkOutput($sformatf("ch1_tick_m%0d", m), tick[1], ((m - 1) % 5 == 0) ? 1 : 0);
      checkOutput($sformatf("ch0_clk_m%0d", m), clk_out[0], ((m - 1) % 2 == 0) ? 1 : 0);
      if (m == 1)
        checkOutput("w1_ready_back", cfg_ready, 1);
      if (m >= 16)
        checkOutput($sformatf("w1_locked_m%0d", m), locked, (m == 17) ? 1 : 0);
    end

    // Phase offset and high boundaries, programmed in IDLE
    en = 1'b0;
    stepClock();
    checkOutput("idle_clk_out", clk_out, 0);
    checkOutput("idle_locked", locked, 0);
    applyStimulus(2'd0, 8'd4, 8'd2, 8'd0);
    applyStimulus(2'd1, 8'd4, 8'd7, 8'd0);
    applyStimulus(2'd2, 8'd4, 8'd2, 8'd1);
    applyStimulus(2'd3, 8'd4, 8'd0, 8'd0);
    checkOutput("idle_wr_clk_out", clk_out, 0);
    en = 1'b1;
    stepClock();
    for (int m = 1; m <= 17; m++) begin
      stepClock();
      if (m <= 8) begin
        checkOutput($sformatf("ph_clk_m%0d", m), clk_out, exp_clk_a[m-1]);
        checkOutput($sformatf("ph_tick_m%0d", m), tick, exp_tick_a[m-1]);
      end
      if (m >= 16)
        checkOutput($sformatf("ph_locked_m%0d", m), locked, (m == 17) ? 1 : 0);
    end

    // Rejected writes while locked: div=1 then div=0
    applyStimulus(2'd0, 8'd1, 8'd1, 8'd0);
    checkOutput("rej1_cfg_err", cfg_err, 1);
    checkOutput("rej1_locked", locked, 1);
    checkOutput("rej1_cfg_ready", cfg_ready, 1);
    checkOutput("rej1_clk_out", clk_out, 4'b0011);
    applyStimulus(2'd2, 8'd0, 8'd1, 8'd0);
    checkOutput("rej2_cfg_err", cfg_err, 1);
    checkOutput("rej2_clk_out", clk_out, 4'b0010);
    stepClock();
    checkOutput("rej_err_clear", cfg_err, 0);
    checkOutput("rej_locked", locked, 1);
    checkOutput("rej_clk_out", clk_out, 4'b0110);

    // en drops together with a legal write: IDLE wins, shadow still updates
    en = 1'b0;
    applyStimulus(2'd2, 8'd4, 8'd2, 8'd9);
    checkOutput("endrop_clk_out", clk_out, 0);
    checkOutput("endrop_tick", tick, 0);
    checkOutput("endrop_locked", locked, 0);
    checkOutput("endrop_cfg_ready", cfg_ready, 1);
    checkOutput("endrop_cfg_err", cfg_err, 0);
    applyStimulus(2'd3, 8'd255, 8'd1, 8'd0);
    en = 1'b1;
    stepClock();
    for (int m = 1; m <= 257; m++) begin
      stepClock();
      if (m <= 5) begin
        checkOutput($sformatf("bnd_clk_m%0d", m), clk_out, exp_clk_b[m-1]);
        checkOutput($sformatf("bnd_tick_m%0d", m), tick, exp_tick_b[m-1]);
      end
      if (m == 17)
        checkOutput("bnd_locked", locked, 1);
      if (m == 255)
        checkOutput("div255_clk_m255", clk_out[3], 0);
      if (m == 256) begin
        checkOutput("div255_clk_m256", clk_out[3], 1);
        checkOutput("div255_tick_m256", tick[3], 1);
      end
      if (m == 257)
        checkOutput("div255_clk_m257", clk_out[3], 0);
    end

    // Reset mid-SETTLE returns everything, including shadows, to defaults
    applyStimulus(2'd0, 8'd6, 8'd3, 8'd2);
    stepClock();
    stepClock();
    checkOutput("settle_locked", locked, 0);
    rst_n = 1'b0;
    stepClock();
    checkOutput("mrst_clk_out", clk_out, 0);
    checkOutput("mrst_tick", tick, 0);
    checkOutput("mrst_locked", locked, 0);
    checkOutput("mrst_cfg_err", cfg_err, 0);
    checkOutput("mrst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    stepClock();
    checkOutput("mrst_e0_ready", cfg_ready, 0);
    stepClock();
    checkOutput("mrst_def_clk_m1", clk_out, 4'hF);
    checkOutput("mrst_def_tick_m1", tick, 4'hF);
    stepClock();
    checkOutput("mrst_def_clk_m2", clk_out, 4'h0);
    checkOutput("mrst_def_tick_m2", tick, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
